// File: rtl/link_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : link_rx                                                      |
// | Description : UART 8N1 receiver with a small receive FIFO, exposed on the  |
// |               CPU bus at 0xff01 (data) and 0xff03 (status/control).        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module link_rx #(
  parameter int CLKS_PER_BIT = 36,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  input  logic        UART_RX,
  output logic        interrupt
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_CYC_W = $clog2(CLKS_PER_BIT);

  localparam logic [c_CYC_W-1:0] c_BIT_LAST  = c_CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CYC_W-1:0] c_HALF_LAST = c_CYC_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]        c_ADDR_DATA = 16'hff01;
  localparam logic [15:0]        c_ADDR_STAT = 16'hff03;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_t;

  // Synchronizer and receiver state
  logic               r_rx_meta;
  logic               r_rxs;
  rx_state_t          r_state;
  rx_state_t          w_state_nx;
  logic [c_CYC_W-1:0] r_cyc;
  logic [c_CYC_W-1:0] w_cyc_nx;
  logic [2:0]         r_bit;
  logic [2:0]         w_bit_nx;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nx;
  logic               w_push_req;
  logic               w_frame_set;

  // FIFO and flags
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overrun;
  logic               r_frame_err;

  logic               w_stat_wr;
  logic               w_pop;
  logic               w_full;
  logic               w_push_ok;
  logic               w_overrun_set;
  logic [3:0]         w_cnt4;
  logic [7:0]         w_status;
  logic [7:0]         w_rd_data;
  logic               w_unused_bits;

  assign w_unused_bits = ^{indata[7], indata[4:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= UART_RX;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cyc   <= w_cyc_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cyc_nx    = r_cyc + c_CYC_W'(1);
    w_bit_nx    = r_bit;
    w_shift_nx  = r_shift;
    w_push_req  = 1'b0;
    w_frame_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cyc_nx = '0;
        if (!r_rxs) w_state_nx = S_START;
      end
      S_START: begin
        if (r_cyc == c_HALF_LAST) begin
          w_cyc_nx   = '0;
          w_bit_nx   = '0;
          w_state_nx = r_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cyc == c_BIT_LAST) begin
          w_cyc_nx          = '0;
          w_shift_nx[r_bit] = r_rxs;
          w_bit_nx          = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cyc == c_BIT_LAST) begin
          w_cyc_nx = '0;
          if (r_rxs) begin
            w_push_req = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_frame_set = 1'b1;
            w_state_nx  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_cyc_nx = '0;
        if (r_rxs) w_state_nx = S_IDLE;
      end
      default: begin
        w_cyc_nx   = '0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_stat_wr     = store && (address == c_ADDR_STAT);
  assign w_pop         = w_stat_wr && indata[0] && (r_count != '0);
  assign w_full        = (r_count == c_FULL);
  assign w_push_ok     = w_push_req && (!w_full || w_pop);
  assign w_overrun_set = w_push_req && !w_push_ok;

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      interrupt   <= 1'b0;
      outdata     <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_overrun_set)                r_overrun <= 1'b1;
      else if (w_stat_wr && indata[6])  r_overrun <= 1'b0;

      if (w_frame_set)                  r_frame_err <= 1'b1;
      else if (w_stat_wr && indata[5])  r_frame_err <= 1'b0;

      interrupt <= w_push_ok;

      if (load && !store) outdata <= w_rd_data;
    end
  end

  if (c_CNT_W >= 4) begin : g_cnt_wide
    assign w_cnt4 = r_count[3:0];
  end else begin : g_cnt_narrow
    assign w_cnt4 = {{(4 - c_CNT_W){1'b0}}, r_count};
  end

  assign w_status = {(r_count != '0), r_overrun, r_frame_err, 1'b0, w_cnt4};

  always_comb begin
    w_rd_data = '0;
    if (address == c_ADDR_DATA) begin
      if (r_count != '0) w_rd_data = r_mem[r_rd_ptr];
    end else if (address == c_ADDR_STAT) begin
      w_rd_data = w_status;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_link_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_link_rx                                                   |
// | Description : Directed scoreboard bench for the link_rx UART receiver.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_link_rx;

  localparam int CPB = 36;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  indata;
  logic [7:0]  outdata;
  logic        load;
  logic        store;
  logic        UART_RX;
  logic        interrupt;

  always #5 clock = ~clock;

  link_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .address   (address),
    .indata    (indata),
    .outdata   (outdata),
    .load      (load),
    .store     (store),
    .UART_RX   (UART_RX),
    .interrupt (interrupt)
  );

  int         n_chk   = 0;
  int         n_fail  = 0;
  int         irq_cnt = 0;
  int         exp_irq = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp = 8'h00;
  logic [7:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read-data monitor: every load cycle is matched against the scoreboard
  always @(posedge clock) begin
    if (load === 1'b1) begin
      #1;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no read", outdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (outdata !== mon_exp) begin
          n_fail++;
          $display("FAIL rd_data: got 0x%0h, expected 0x%0h", outdata, mon_exp);
        end
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (interrupt === 1'b1) irq_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp);
    @(negedge clock);
    address = a;
    load    = 1'b1;
    exp_q.push_back(exp);
    last_exp = exp;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    address = a;
    indata  = d;
    store   = 1'b1;
    @(negedge clock);
    store = 1'b0;
  endtask

  // load and store together: the write happens, outdata must hold
  task automatic ldst(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    address = a;
    indata  = d;
    load    = 1'b1;
    store   = 1'b1;
    exp_q.push_back(last_exp);
    @(negedge clock);
    load  = 1'b0;
    store = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clock);
    UART_RX = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      cyc(CPB);
    end
    UART_RX = stop_bit;
    cyc(CPB);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; load = 1'b0; store = 1'b0;
    address = 16'h0000; indata = 8'h00; UART_RX = 1'b1;
    cyc(3);
    chk("reset_outdata", {24'h0, outdata}, 32'h00);
    chk("reset_interrupt", {31'h0, interrupt}, 32'h0);
    reset = 1'b0;
    cyc(2);
    rd(16'hff03, 8'h00);

    // Single byte, status, data, pop via combined load/store
    send_byte(8'hA5, 1'b1);
    cyc(4);
    exp_irq = 1;
    chk("irq_a5", irq_cnt, exp_irq);
    rd(16'hff03, 8'h81);
    rd(16'hff01, 8'hA5);
    ldst(16'hff03, 8'h01);
    rd(16'hff03, 8'h00);
    rd(16'hff01, 8'h00);
    rd(16'h1234, 8'h00);
    wr(16'hff01, 8'h77);
    rd(16'hff03, 8'h00);

    // Short glitch is rejected, next byte arrives intact
    @(negedge clock);
    UART_RX = 1'b0;
    cyc(14);
    UART_RX = 1'b1;
    cyc(CPB);
    chk("irq_glitch", irq_cnt, exp_irq);
    rd(16'hff03, 8'h00);
    send_byte(8'h3C, 1'b1);
    cyc(4);
    exp_irq = 2;
    chk("irq_3c", irq_cnt, exp_irq);
    rd(16'hff03, 8'h81);
    rd(16'hff01, 8'h3C);
    wr(16'hff03, 8'h01);
    rd(16'hff03, 8'h00);

    // Overflow: five bytes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1);
      cyc(4);
    end
    exp_irq = 6;
    chk("irq_overflow", irq_cnt, exp_irq);
    rd(16'hff03, 8'hC4);
    for (int i = 1; i <= 4; i++) begin
      rd(16'hff01, 8'(i));
      wr(16'hff03, 8'h01);
    end
    rd(16'hff03, 8'h40);
    wr(16'hff03, 8'h40);
    rd(16'hff03, 8'h00);

    // Framing error followed by a held-low line
    send_byte(8'h55, 1'b0);
    cyc(3 * CPB);
    UART_RX = 1'b1;
    cyc(CPB);
    chk("irq_frame_err", irq_cnt, exp_irq);
    rd(16'hff03, 8'h20);
    send_byte(8'h7E, 1'b1);
    cyc(4);
    exp_irq = 7;
    chk("irq_7e", irq_cnt, exp_irq);
    rd(16'hff03, 8'hA1);
    rd(16'hff01, 8'h7E);
    wr(16'hff03, 8'h21);
    rd(16'hff03, 8'h00);

    // Reset in the middle of a frame with bytes buffered
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    cyc(4);
    exp_irq = 9;
    chk("irq_pre_reset", irq_cnt, exp_irq);
    rd(16'hff03, 8'h82);
    fork
      send_byte(8'hF0, 1'b1);
      begin
        cyc(1 + 5 * CPB + 18);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
      end
    join
    cyc(4);
    chk("post_reset_outdata", {24'h0, outdata}, 32'h00);
    chk("irq_post_reset", irq_cnt, exp_irq);
    rd(16'hff03, 8'h00);
    send_byte(8'h99, 1'b1);
    cyc(4);
    exp_irq = 10;
    chk("irq_99", irq_cnt, exp_irq);
    rd(16'hff03, 8'h81);
    rd(16'hff01, 8'h99);
    wr(16'hff03, 8'h01);

    // Push into a full FIFO in the same cycle as a pop
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'hA0 + 8'(i), 1'b1);
    end
    cyc(4);
    exp_irq = 14;
    chk("irq_fill", irq_cnt, exp_irq);
    rd(16'hff03, 8'h84);
    fork
      send_byte(8'hB5, 1'b1);
      begin
        cyc(344);
        wr(16'hff03, 8'h01);
      end
    join
    cyc(4);
    exp_irq = 15;
    chk("irq_full_pop", irq_cnt, exp_irq);
    rd(16'hff03, 8'h84);
    rd(16'hff01, 8'hA2);
    wr(16'hff03, 8'h01);
    rd(16'hff01, 8'hA3);
    wr(16'hff03, 8'h01);
    rd(16'hff01, 8'hA4);
    wr(16'hff03, 8'h01);
    rd(16'hff01, 8'hB5);
    wr(16'hff03, 8'h01);
    rd(16'hff03, 8'h00);

    cyc(4);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/link_rx.md
Name: link_rx

Overview:
- UART receive side of the serial link. The existing link block only transmits.
- Samples the UART_RX line, deframes 8N1 bytes, and buffers them in a small FIFO.
- Exposes the bytes to the CPU through the memory-mapped bus at 0xff01 (data) and 0xff03 (status/control).
- Raises a one-cycle interrupt pulse per accepted byte; this pulse feeds the serial interrupt flag (IF bit 3).

Parameters:
- CLKS_PER_BIT, 36, clock cycles per UART bit. 4.194304 MHz / 115200, rounded; must be >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- clock  input  1  system clock (CPU bus clock); all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  16  CPU bus address.
- indata  input  8  CPU write data.
- outdata  output  8  CPU read data, registered.
- load  input  1  CPU read strobe, one cycle.
- store  input  1  CPU write strobe, one cycle; has priority over load.
- UART_RX  input  1  asynchronous serial input; idles high.
- interrupt  output  1  one-cycle pulse when a byte is pushed into the FIFO.

Behaviour:
- Reset (synchronous, active-high):
  - outdata=0, interrupt=0.
  - FIFO empty, overrun=0, frame_err=0.
  - Receiver in IDLE; synchronizer flops set to 1.
  - Reset mid-frame discards the partial byte and all buffered bytes.
- Input synchronization:
  - UART_RX passes through a 2-flop synchronizer.
  - All decisions use the synchronized value `rxs`, which lags UART_RX by 2 cycles.
- Receiver FSM (bit counter 0..7, cycle counter 0..CLKS_PER_BIT-1):
  - IDLE: on `rxs`=0, clear the cycle counter and go to START.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then sample.
    - Sample 1: glitch, return to IDLE with nothing logged.
    - Sample 0: reset the counters and go to DATA.
  - DATA: every CLKS_PER_BIT cycles, sample `rxs` into shift[bit], LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - Sample 1: push the byte and go to IDLE.
    - Sample 0: set frame_err, discard the byte, go to BREAK.
  - BREAK: stay until `rxs`=1, then go to IDLE. A held-low line yields exactly one frame error.
- Push:
  - FIFO not full: write the byte and pulse interrupt=1 in the same cycle the push is recorded.
  - FIFO full: drop the byte, set overrun, no interrupt. FIFO contents are unchanged.
- FIFO:
  - Circular buffer with wrapping read/write pointers and count 0..FIFO_DEPTH.
  - Push and pop in the same cycle: both take effect, count unchanged. When full, a same-cycle pop makes room, so the push succeeds with no overrun.
  - Pop when empty is ignored.
- Register map; addresses other than 0xff01 and 0xff03 are ignored on writes:
  - 0xff01 read: outdata = FIFO head, or 0 if empty. The read does not pop.
  - 0xff01 write: ignored by this block.
  - 0xff03 read: outdata = {valid(count!=0), overrun, frame_err, 1'b0, count[3:0]}; count field zero-extended/truncated to 4 bits.
  - 0xff03 write, any indata bits may be combined:
    - indata[0]=1 pops the head.
    - indata[6]=1 clears overrun.
    - indata[5]=1 clears frame_err.
  - A clear in the same cycle as a new set event: the set wins.
  - Any other address read: outdata = 0.
- outdata timing and priority:
  - outdata updates on the clock edge at which load is sampled; the value is valid in the following cycle.
  - outdata holds its value when load=0.
  - load and store in the same cycle: only the store is performed, and outdata holds.

Test Plan:
- Reset, then send 0xA5 at CLKS_PER_BIT=36 -> one interrupt pulse; read 0xff03 = 0x81; read 0xff01 = 0xA5; write 0xff03 = 0x01, then read 0xff03 = 0x00.
- 0.4-bit low glitch on UART_RX in IDLE -> no interrupt, FIFO empty, frame_err=0, and a following byte 0x3C is received correctly.
- Send 5 bytes 0x01..0x05 without popping, FIFO_DEPTH=4 -> 4 interrupts; status = 0xC4. Pop order 0x01..0x04. Write 0xff03 = 0x40 clears overrun; final status 0x00.
- Send 0x55 with stop bit low, then hold the line low for 3 bit times -> status 0x20, no interrupt, no push; after the line returns high, 0x7E is received normally.
- Assert reset at DATA bit 4 with 2 bytes buffered -> status 0x00, outdata 0x00; the remainder of the interrupted frame produces no push or error; the next full frame 0x99 is received.
- Byte completes while the FIFO is full and a pop is written in the same cycle -> count stays 4, overrun=0, interrupt pulses, and the new byte is the last entry.
